// File: rtl/jtag_apb_cmd_exec.sv
// JTAG-to-APB command executor: decodes an 88-bit command word, runs one or two
// APB4 transfers (32- or 48-bit payload) and returns a 49-bit {suberr, data} response.
module jtag_apb_cmd_exec #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cmd_valid,
   input  logic [87:0] cmd,
   output logic        busy,
   output logic        resp_valid,
   output logic [48:0] resp,
   output logic        overrun,
   output logic [31:0] paddr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] pwdata,
   output logic [3:0]  pstrb,
   output logic [2:0]  pprot,
   input  logic        pready,
   input  logic [31:0] prdata,
   input  logic        pslverr
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RESP
   } state_t;

   localparam int unsigned   CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        state_q;
   logic          beat_q;
   logic          d32_q;
   logic          wr_q;
   logic [15:0]   data_hi_q;
   logic [47:0]   rdata_q;
   logic          suberr_q;
   logic [CW-1:0] cnt_q;

   logic          busy_q;
   logic          resp_valid_q;
   logic [48:0]   resp_q;
   logic          overrun_q;
   logic [31:0]   paddr_q;
   logic          psel_q;
   logic          penable_q;
   logic          pwrite_q;
   logic [31:0]   pwdata_q;
   logic [3:0]    pstrb_q;

   logic [47:0]   rdata_d;
   logic          suberr_d;
   logic          last_beat;
   logic          timed_out;
   logic          unused_rsvd;

   assign unused_rsvd = ^cmd[55:51];

   // Read data and error status as they would stand if this ACCESS cycle completes.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      rdata_d  = rdata_q;
      suberr_d = suberr_q | pslverr;
      if (!wr_q) begin
         if (beat_q) rdata_d[47:32] = prdata[15:0];
         else        rdata_d[31:0]  = prdata;
      end
   end

   assign last_beat = beat_q | d32_q;
   assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         beat_q       <= 1'b0;
         d32_q        <= 1'b0;
         wr_q         <= 1'b0;
         data_hi_q    <= '0;
         rdata_q      <= '0;
         suberr_q     <= 1'b0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_q       <= '0;
         overrun_q    <= 1'b0;
         paddr_q      <= '0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         pwdata_q     <= '0;
         pstrb_q      <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         resp_valid_q <= 1'b0;
         if (cmd_valid && state_q != S_IDLE) overrun_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  overrun_q <= 1'b0;
                  busy_q    <= 1'b1;
                  d32_q     <= cmd[50];
                  wr_q      <= cmd[49];
                  data_hi_q <= cmd[47:32];
                  rdata_q   <= '0;
                  suberr_q  <= 1'b0;
                  beat_q    <= 1'b0;
                  cnt_q     <= '0;
                  if (cmd[49] == cmd[48]) begin
                     // Neither or both of read/write: answer without touching the bus.
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_q       <= {cmd[49] & cmd[48], 48'h0};
                  end else begin
                     state_q   <= S_SETUP;
                     psel_q    <= 1'b1;
                     penable_q <= 1'b0;
                     pwrite_q  <= cmd[49];
                     paddr_q   <= cmd[87:56];
                     pwdata_q  <= cmd[31:0];
                     pstrb_q   <= cmd[49] ? 4'hF : 4'h0;
                  end
               end
            end

            S_SETUP: begin
               penable_q <= 1'b1;
               cnt_q     <= '0;
               state_q   <= S_ACCESS;
            end

            S_ACCESS: begin
               if (pready) begin
                  rdata_q  <= rdata_d;
                  suberr_q <= suberr_d;
                  if (!last_beat) begin
                     // psel stays high into the second SETUP for a back-to-back transfer.
                     beat_q    <= 1'b1;
                     penable_q <= 1'b0;
                     paddr_q   <= paddr_q + 32'd4;
                     pwdata_q  <= {16'h0, data_hi_q};
                     pstrb_q   <= wr_q ? 4'b0011 : 4'b0000;
                     state_q   <= S_SETUP;
                  end else begin
                     psel_q       <= 1'b0;
                     penable_q    <= 1'b0;
                     resp_valid_q <= 1'b1;
                     resp_q       <= {suberr_d, wr_q ? 48'h0 : rdata_d};
                     state_q      <= S_RESP;
                  end
               end else if (timed_out) begin
                  psel_q       <= 1'b0;
                  penable_q    <= 1'b0;
                  suberr_q     <= 1'b1;
                  resp_valid_q <= 1'b1;
                  resp_q       <= {1'b1, wr_q ? 48'h0 : rdata_q};
                  state_q      <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_RESP: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign resp_valid = resp_valid_q;
   assign resp       = resp_q;
   assign overrun    = overrun_q;
   assign paddr      = paddr_q;
   assign psel       = psel_q;
   assign penable    = penable_q;
   assign pwrite     = pwrite_q;
   assign pwdata     = pwdata_q;
   assign pstrb      = pstrb_q;
   assign pprot      = 3'b000;

endmodule

// File: tb/tb_jtag_apb_cmd_exec.sv
// Directed bench for jtag_apb_cmd_exec: an APB completer model checks every bus
// beat against a queue of expected beats; responses are checked against a queue.
module tb_jtag_apb_cmd_exec;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [87:0] cmd = '0;
   logic        busy, resp_valid, overrun;
   logic [48:0] resp;
   logic [31:0] paddr, pwdata;
   logic        psel, penable, pwrite;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        pready = 1'b0;
   logic [31:0] prdata = '0;
   logic        pslverr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int acc_n   = 0;

   typedef struct {
      int          waits;
      bit          hold;
      logic [31:0] addr;
      bit          wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] rdata;
      bit          err;
   } beat_t;

   typedef struct {
      logic [48:0] resp;
      int          cyc;
   } rsp_t;

   beat_t slv_q[$];
   rsp_t  exp_q[$];
   beat_t cur;
   rsp_t  got;

   jtag_apb_cmd_exec #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .cmd_valid  (cmd_valid),
      .cmd        (cmd),
      .busy       (busy),
      .resp_valid (resp_valid),
      .resp       (resp),
      .overrun    (overrun),
      .paddr      (paddr),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .pwdata     (pwdata),
      .pstrb      (pstrb),
      .pprot      (pprot),
      .pready     (pready),
      .prdata     (prdata),
      .pslverr    (pslverr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void add_beat(input int waits, input bit hold, input logic [31:0] addr,
                                    input bit wr, input logic [31:0] wdata, input logic [3:0] strb,
                                    input logic [31:0] rdata, input bit err);
      slv_q.push_back('{waits, hold, addr, wr, wdata, strb, rdata, err});
   endfunction

   // APB completer: checks the request against the expected beat every selected cycle.
   always @(negedge clk) begin
      pready  = 1'b0;
      prdata  = '0;
      pslverr = 1'b0;
      if (psel) begin
         if (slv_q.size() == 0) begin
            check("unexpected_psel", {63'h0, psel}, 64'h0);
         end else begin
            cur = slv_q[0];
            check("paddr",  {32'h0, paddr},  {32'h0, cur.addr});
            check("pwrite", {63'h0, pwrite}, {63'h0, cur.wr});
            check("pwdata", {32'h0, pwdata}, {32'h0, cur.wdata});
            check("pstrb",  {60'h0, pstrb},  {60'h0, cur.strb});
            check("pprot",  {61'h0, pprot},  64'h0);
            if (penable) begin
               if (!cur.hold && acc_n >= cur.waits) begin
                  pready  = 1'b1;
                  prdata  = cur.rdata;
                  pslverr = cur.err;
                  void'(slv_q.pop_front());
                  acc_n = 0;
               end else begin
                  acc_n++;
               end
            end
         end
      end else begin
         acc_n = 0;
      end
   end

   // Response scoreboard: value and cycle of arrival.
   always @(negedge clk) begin
      if (resp_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp_valid", {63'h0, resp_valid}, 64'h0);
         end else begin
            got = exp_q.pop_front();
            check("resp",         {15'h0, resp}, {15'h0, got.resp});
            check("resp_cycle",   64'(cyc),      64'(got.cyc));
            check("busy_at_resp", {63'h0, busy}, 64'h1);
         end
      end
   end

   task automatic send(input logic [31:0] addr, input bit d32, input bit wr, input bit rd,
                       input logic [47:0] data, input int lat, input logic [48:0] exp_resp);
      @(posedge clk);
      #1;
      cmd       = {addr, 5'b10101, d32, wr, rd, data};
      cmd_valid = 1'b1;
      exp_q.push_back('{exp_resp, cyc + lat});
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_pending"}, 64'(exp_q.size()), 64'h0);
      exp_q.delete();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_psel"},       {63'h0, psel},       64'h0);
      check({tag, "_penable"},    {63'h0, penable},    64'h0);
      check({tag, "_pwrite"},     {63'h0, pwrite},     64'h0);
      check({tag, "_paddr"},      {32'h0, paddr},      64'h0);
      check({tag, "_pwdata"},     {32'h0, pwdata},     64'h0);
      check({tag, "_pstrb"},      {60'h0, pstrb},      64'h0);
      check({tag, "_pprot"},      {61'h0, pprot},      64'h0);
      check({tag, "_busy"},       {63'h0, busy},       64'h0);
      check({tag, "_resp_valid"}, {63'h0, resp_valid}, 64'h0);
      check({tag, "_resp"},       {15'h0, resp},       64'h0);
      check({tag, "_overrun"},    {63'h0, overrun},    64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rstn = 1'b1;

      // 32-bit write, zero wait states
      add_beat(0, 0, 32'h1000_0010, 1, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
      send(32'h1000_0010, 1, 1, 0, 48'h0000_DEAD_BEEF, 3, 49'h0);
      check("busy_during_cmd", {63'h0, busy}, 64'h1);
      wait_resp("wr32");
      @(posedge clk);
      #1;
      check("busy_after_resp", {63'h0, busy}, 64'h0);

      // 48-bit read, two wait states on beat 0
      add_beat(2, 0, 32'h2000_0000, 0, 32'h0, 4'h0, 32'h1122_3344, 0);
      add_beat(0, 0, 32'h2000_0004, 0, 32'h0, 4'h0, 32'hAAAA_5566, 0);
      send(32'h2000_0000, 0, 0, 1, 48'h0, 7, {1'b0, 48'h5566_1122_3344});
      wait_resp("rd48");
      repeat (3) @(posedge clk);
      #1;
      check("resp_hold", {15'h0, resp}, {15'h0, 1'b0, 48'h5566_1122_3344});

      // 48-bit write with pslverr on beat 0
      add_beat(0, 0, 32'h3000_0008, 1, 32'h0123_4567, 4'hF,    32'h0, 1);
      add_beat(0, 0, 32'h3000_000C, 1, 32'h0000_ABCD, 4'b0011, 32'h0, 0);
      send(32'h3000_0008, 0, 1, 0, 48'hABCD_0123_4567, 5, {1'b1, 48'h0});
      wait_resp("slverr48");

      // 48-bit write whose second beat address wraps
      add_beat(0, 0, 32'hFFFF_FFFC, 1, 32'h0000_0001, 4'hF,    32'h0, 0);
      add_beat(0, 0, 32'h0000_0000, 1, 32'h0000_5A5A, 4'b0011, 32'h0, 0);
      send(32'hFFFF_FFFC, 0, 1, 0, 48'h5A5A_0000_0001, 5, 49'h0);
      wait_resp("wrap48");

      // Timeout: completer never answers
      add_beat(0, 1, 32'h4000_0000, 0, 32'h0, 4'h0, 32'h0, 0);
      send(32'h4000_0000, 1, 0, 1, 48'h0, 6, {1'b1, 48'h0});
      wait_resp("timeout");
      check("timeout_psel", {63'h0, psel}, 64'h0);
      slv_q.delete();
      add_beat(0, 0, 32'h4000_0004, 0, 32'h0, 4'h0, 32'h0BAD_F00D, 0);
      send(32'h4000_0004, 1, 0, 1, 48'h0, 3, {1'b0, 48'h0000_0BAD_F00D});
      wait_resp("after_timeout");

      // Reset while penable is high
      add_beat(0, 1, 32'h6000_0000, 0, 32'h0, 4'h0, 32'h0, 0);
      send(32'h6000_0000, 1, 0, 1, 48'h0, 3, 49'h0);
      n = 0;
      while (!penable && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("penable_before_reset", {63'h0, penable}, 64'h1);
      #1 rstn = 1'b0;
      #1;
      check_idle_outputs("midop_reset");
      slv_q.delete();
      exp_q.delete();
      @(negedge clk);
      rstn = 1'b1;
      add_beat(0, 0, 32'h7000_0010, 0, 32'h0, 4'h0, 32'hCAFE_F00D, 0);
      send(32'h7000_0010, 1, 0, 1, 48'h0, 3, {1'b0, 48'h0000_CAFE_F00D});
      wait_resp("after_reset");

      // Command pulsed during ACCESS is dropped and flags overrun
      add_beat(3, 0, 32'h5000_0000, 1, 32'h1234_5678, 4'hF, 32'h0, 0);
      send(32'h5000_0000, 1, 1, 0, 48'h0000_1234_5678, 6, 49'h0);
      @(posedge clk);
      #1;
      cmd       = {32'h9000_0000, 5'b0, 1'b1, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFF};
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("overrun_set", {63'h0, overrun}, 64'h1);
      wait_resp("overrun_cmd");
      check("overrun_sticky", {63'h0, overrun}, 64'h1);

      // read=write=1 answers at cycle 1 with suberr and clears overrun
      send(32'h5000_0100, 1, 1, 1, 48'h1, 1, {1'b1, 48'h0});
      check("overrun_cleared", {63'h0, overrun}, 64'h0);
      wait_resp("both_set");
      check("both_set_psel", {63'h0, psel}, 64'h0);

      // read=write=0 answers at cycle 1 with zero
      send(32'h5000_0200, 1, 0, 0, 48'h1234, 1, 49'h0);
      wait_resp("none_set");

      // cmd_valid in the resp_valid cycle is rejected
      add_beat(0, 0, 32'h8000_0000, 1, 32'h0000_00AA, 4'hF, 32'h0, 0);
      send(32'h8000_0000, 1, 1, 0, 48'h0000_0000_00AA, 3, 49'h0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("resp_valid_cycle3", {63'h0, resp_valid}, 64'h1);
      cmd       = {32'h8000_0040, 5'b0, 1'b1, 1'b1, 1'b0, 48'h0000_0000_00BB};
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("simul_overrun", {63'h0, overrun}, 64'h1);
      check("simul_busy",    {63'h0, busy},    64'h0);
      wait_resp("simul");
      repeat (4) @(posedge clk);
      #1;
      check("simul_no_resp", {63'h0, resp_valid}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/jtag_apb_cmd_exec.md
# jtag_apb_cmd_exec

Executes JTAG-to-APB command words on an APB4 bus and returns response words. It sits between the JTAG DR update logic, already synchronized into the system clock domain, and the APB fabric. It decodes the 88-bit APB command word and runs one or two APB transfers. It then returns the 49-bit `{suberr, data[47:0]}` response word with a one-cycle valid strobe.

## Interface
- `TIMEOUT_CYCLES`, default 256: maximum ACCESS-phase cycles per transfer before abort; 0 disables the timeout.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: single-cycle strobe indicating `cmd` holds a new command.
- `cmd` in 88: `{addr[31:0], rsvd[4:0], d32bit, write, read, data[47:0]}`, bits 87..0.
- `busy` out 1: high from the cycle after acceptance until the cycle of `resp_valid` inclusive.
- `resp_valid` out 1: single-cycle strobe indicating a completed command.
- `resp` out 49: `{suberr, data[47:0]}`; holds its value until the next `resp_valid`.
- `overrun` out 1: sticky; set when `cmd_valid` arrives while `busy`; cleared on the next accepted command.
- `paddr` out 32, `psel` out 1, `penable` out 1, `pwrite` out 1, `pwdata` out 32, `pstrb` out 4, `pprot` out 3: APB4 requester outputs.
- `pready` in 1, `prdata` in 32, `pslverr` in 1: APB4 completer inputs.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS, RESP.
- **IDLE:** `cmd_valid` latches `cmd` and clears `overrun`, then branches:
  - read=write=0: go to RESP with resp=0 and no bus activity.
  - read=write=1: go to RESP with suberr=1, data=0, and no bus activity.
  - Otherwise: go to SETUP with beat 0.
- **Beat 0:**
  - paddr=addr, pwdata=data[31:0], pstrb=4'hF for writes, 4'h0 for reads.
- **Beat 1** (only when d32bit=0):
  - paddr=addr+4, with 32-bit wrap (0xFFFF_FFFC+4 → 0x0000_0000).
  - pwdata={16'h0, data[47:32]}, pstrb=4'b0011 for writes.
- **Fixed signals:** pwrite=write for the whole command; pprot=3'b000.
- **SETUP:** psel=1, penable=0; go to ACCESS next cycle.
- **ACCESS:** psel=1, penable=1; stay until pready=1. On pready:
  - For reads, capture prdata: beat 0 → data[31:0], beat 1 → data[47:32] from prdata[15:0], prdata[31:16] discarded.
  - suberr |= pslverr.
  - If beat 0 and d32bit=0: go to SETUP with beat 1. Otherwise go to RESP.
- **Timeout:** counts ACCESS cycles with pready=0. If the count reaches TIMEOUT_CYCLES:
  - Deassert psel/penable and set suberr=1.
  - Skip any remaining beat; uncaptured read data is 0.
  - Go to RESP.
- **pslverr on beat 0:** beat 1 still executes. suberr is the OR over both beats.
- **Response data:**
  - Writes: resp.data=0.
  - d32bit reads: resp.data[47:32]=0.
- **RESP:** resp_valid=1 and resp updated in the same cycle; return to IDLE next cycle.
- **Busy behaviour:** cmd_valid while busy is dropped and sets overrun. The in-flight command is unaffected.
- rsvd bits are ignored.

## Timing
- **Reset values:** psel, penable, pwrite, paddr, pwdata, pstrb, pprot, busy, resp_valid, resp, overrun are all 0; FSM=IDLE; counter=0.
- **Reset mid-transfer:** rstn low aborts immediately and asynchronously. psel drops without completion and no response is produced.
- **Minimum latency** (zero-wait, d32bit=1): cmd_valid at cycle 0 → SETUP at cycle 1 → ACCESS+pready at cycle 2 → resp_valid at cycle 3.
- **48-bit command:** resp_valid at cycle 5 with zero wait states; each wait state adds one cycle.
- **Non-bus command** (read=write=0, or both set): resp_valid at cycle 1.
- **APB bus rules:**
  - APB outputs are registered.
  - paddr, pwrite, pwdata, pstrb are stable from SETUP through the pready cycle.
  - psel stays high between beat 0 ACCESS and beat 1 SETUP (back-to-back transfer).
- **Next command:** a command may be accepted in the cycle after resp_valid, when busy=0.
- **Simultaneous events:** cmd_valid in the same cycle as resp_valid is rejected and sets overrun.

## Test plan
- **32-bit write, zero-wait:** cmd addr=0x1000_0010, d32bit=1, write=1, data=0x0000_DEAD_BEEF → one transfer with paddr=0x1000_0010, pwdata=0xDEAD_BEEF, pstrb=F. resp_valid at cycle 3, resp=0.
- **48-bit read, 2 wait states on beat 0:** addr=0x2000_0000, d32bit=0, read=1; prdata=0x1122_3344 then 0xAAAA_5566 → paddr 0x2000_0000 then 0x2000_0004. resp={0, 48'h5566_1122_3344}, resp_valid at cycle 7.
- **pslverr on beat 0 of a 48-bit write, data=48'hABCD_0123_4567** → beat 1 still issued with pwdata=0x0000_ABCD, pstrb=4'b0011. resp.suberr=1.
- **Timeout:** TIMEOUT_CYCLES=4, pready held 0 → psel drops after 4 ACCESS cycles. resp={1, 48'h0}; next command accepted normally.
- **Overrun and illegal commands:**
  - cmd_valid pulsed during ACCESS → ignored, overrun=1; first command completes unchanged.
  - The next accepted command clears overrun.
  - read=write=1 → resp_valid at cycle 1 with suberr=1 and no psel.
- **Reset mid-op:** rstn asserted while penable=1 → all outputs 0 immediately. After release, a fresh 32-bit read completes with correct data.
